// File: rtl/uart_coe_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_coe_loader
// Description : 8N1 UART receiver that packs bytes little-endian into 32-bit
//               words and issues one-cycle write strobes into Instruction
//               Memory (adr[14]=0) and then Data Memory (adr[14]=1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_coe_loader #(
  parameter int CLKS_PER_BIT   = 78,
  parameter int IM_WORDS       = 16384,
  parameter int DM_WORDS       = 16384,
  parameter int TIMEOUT_CYCLES = 7800
) (
  input  logic        iUpgClock,
  input  logic        iUpgResetN,
  input  logic        iUartRx,
  output logic        oUpgWriteEnable,
  output logic [14:0] oUpgAddress,
  output logic [31:0] oUpgData,
  output logic        oUpgDone,
  output logic        oFrameError
);

  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TOTAL_WORDS = IM_WORDS + DM_WORDS;

  localparam logic [BCW-1:0] C_BIT_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] C_BIT_HALF = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TCW-1:0] C_TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [14:0]    C_LAST_WORD = 15'(TOTAL_WORDS - 1);
  localparam logic [14:0]    C_IM_WORDS  = 15'(IM_WORDS);
  localparam logic [13:0]    C_IM_OFFSET = 14'(IM_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic           rx_meta_q, rx_sync_q;
  logic [1:0]     st_q, st_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           w_byte_valid, w_frame_err;

  logic [1:0]     byte_idx_q;
  logic [23:0]    word_q;
  logic [TCW-1:0] tmo_q;
  logic [14:0]    word_cnt_q;
  logic [13:0]    w_dm_idx;
  logic [14:0]    w_adr;

  // Two-flop synchronizer for the asynchronous RX line; resets to idle-high.
  always_ff @(posedge iUpgClock or negedge iUpgResetN) begin
    if (!iUpgResetN) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= iUartRx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX state machine next-state logic: mid-bit sampling, LSB first.
  always_comb begin
    st_d         = st_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (st_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_sync_q) st_d = S_START;
      end
      S_START: begin
        if (bit_cnt_q == C_BIT_HALF) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          st_d      = rx_sync_q ? S_IDLE : S_DATA;  // high here means a glitch
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == C_BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) st_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == C_BIT_LAST) begin
          bit_cnt_d    = '0;
          st_d         = S_IDLE;
          w_byte_valid = rx_sync_q;
          w_frame_err  = !rx_sync_q;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // RX state registers and sticky frame-error flag.
  always_ff @(posedge iUpgClock or negedge iUpgResetN) begin
    if (!iUpgResetN) begin
      st_q        <= S_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      oFrameError <= 1'b0;
    end else begin
      st_q      <= st_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      if (w_frame_err) oFrameError <= 1'b1;
    end
  end

  // Region select: first IM_WORDS go to IM, the rest are re-based into DM.
  // The 14-bit subtraction wraps modulo 2^14, which is exactly the index.
  assign w_dm_idx = word_cnt_q[13:0] - C_IM_OFFSET;
  assign w_adr    = (word_cnt_q < C_IM_WORDS) ? {1'b0, word_cnt_q[13:0]}
                                              : {1'b1, w_dm_idx};

  // Word assembly, partial-word timeout, write strobe and completion.
  always_ff @(posedge iUpgClock or negedge iUpgResetN) begin
    if (!iUpgResetN) begin
      byte_idx_q      <= '0;
      word_q          <= '0;
      tmo_q           <= '0;
      word_cnt_q      <= '0;
      oUpgWriteEnable <= 1'b0;
      oUpgAddress     <= '0;
      oUpgData        <= '0;
      oUpgDone        <= 1'b0;
    end else begin
      oUpgWriteEnable <= 1'b0;
      // An accepted byte takes priority over a simultaneous timeout expiry.
      if (w_byte_valid && !oUpgDone) begin
        tmo_q <= '0;
        if (byte_idx_q == 2'd3) begin
          byte_idx_q      <= '0;
          oUpgWriteEnable <= 1'b1;
          oUpgAddress     <= w_adr;
          oUpgData        <= {shift_q, word_q};
        end else begin
          word_q[{byte_idx_q, 3'b000} +: 8] <= shift_q;
          byte_idx_q <= byte_idx_q + 1'b1;
        end
      end else if (byte_idx_q != 2'd0) begin
        if (tmo_q == C_TMO_LAST) begin
          byte_idx_q <= '0;
          tmo_q      <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
      // Counter advances in the strobe cycle; done follows one cycle later.
      if (oUpgWriteEnable) begin
        word_cnt_q <= word_cnt_q + 1'b1;
        if (word_cnt_q == C_LAST_WORD) oUpgDone <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
